// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the memory-access stage SRAM controller.
//   DATA_W             : data path width (32-bit ARM-subset words)
//   DATA_BASE_DEFAULT  : default byte address of data-memory word 0
//   ADDR_W_DEFAULT     : default SRAM word-address width
//   mem_state_t        : controller state (IDLE / ACCESS / DONE)
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned DATA_BASE_DEFAULT = 1024;
  localparam int unsigned ADDR_W_DEFAULT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_last_read_buf.sv
// ---------------------------------------------------------------------------
// mem_last_read_buf
// One-entry last-read buffer: remembers {valid, word address, data} of the
// most recent completed SRAM read so a repeated load can skip the handshake.
// Only instantiated when MEM_LASTREAD_EN is defined.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (clears valid)
//   i_fill          : capture i_fill_addr / i_fill_data, set valid
//   i_fill_addr     : word address of the completed read
//   i_fill_data     : data returned by the completed read
//   i_inval         : clear valid (a store is being issued)
//   i_lookup_addr   : word address of the load being considered
//   o_hit           : entry valid and tag equals i_lookup_addr
//   o_data          : buffered data
// ---------------------------------------------------------------------------
module mem_last_read_buf
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_inval,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else begin
      // A store and a read completion never occur in the same cycle, but
      // invalidation wins so a stale word can never be served.
      if (i_inval) begin
        r_valid <= 1'b0;
      end else if (i_fill) begin
        r_valid <= 1'b1;
        r_tag   <= i_fill_addr;
        r_data  <= i_fill_data;
      end
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_addr);
  assign o_data = r_data;

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
// Memory-access stage of the 5-stage pipeline. Converts load/store requests
// from the EXE/MEM register into a req/ack handshake with a multi-cycle data
// SRAM and freezes the pipeline while an access is in flight.
// Optional feature macro: MEM_LASTREAD_EN (one-entry last-read buffer that
// lets a repeated load complete without an SRAM access).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   MEM_R_en        : load request
//   MEM_W_en        : store request (a load wins if both are set)
//   ALU_result      : byte address
//   Val_Rm          : store data
//   MEM_read_value  : load data to MEM/WB, held until the next load completes
//   freeze          : combinational pipeline stall
//   mem_req/mem_we  : SRAM request / write strobe (held until mem_ack)
//   mem_addr        : SRAM word address, (ALU_result - DATA_BASE) >> 2
//   mem_wdata       : SRAM write data
//   mem_rdata       : SRAM read data (valid with mem_ack)
//   mem_ack         : SRAM completion pulse
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_BASE = DATA_BASE_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_en,
  input  logic              MEM_W_en,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] Val_Rm,
  output logic [DATA_W-1:0] MEM_read_value,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mem_state_t        r_state, w_state_next;
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic [DATA_W-1:0] r_read_value, w_read_value_next;
  logic              w_freeze;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;

  // Out-of-range addresses simply wrap; the cast keeps the low ADDR_W bits
  // of the word index.
  assign w_word_addr = ADDR_W'((ALU_result - DATA_W'(DATA_BASE)) >> 2);

`ifdef MEM_LASTREAD_EN
  logic w_fill;
  logic w_inval;

  mem_last_read_buf #(
    .ADDR_W(ADDR_W)
  ) u_last_read_buf (
    .clk          (clk),
    .rst          (rst),
    .i_fill       (w_fill),
    .i_fill_addr  (r_mem_addr),
    .i_fill_data  (mem_rdata),
    .i_inval      (w_inval),
    .i_lookup_addr(w_word_addr),
    .o_hit        (w_hit),
    .o_data       (w_hit_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_read_value <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_read_value <= w_read_value_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_mem_req_next    = r_mem_req;
    w_mem_we_next     = r_mem_we;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_read_value_next = r_read_value;
    w_freeze          = 1'b0;
`ifdef MEM_LASTREAD_EN
    w_fill            = 1'b0;
    w_inval           = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (MEM_R_en || MEM_W_en) begin
          w_freeze = 1'b1;
          if (MEM_R_en && w_hit) begin
            // Buffered load: skip the SRAM and finish next cycle.
            w_state_next      = DONE;
            w_read_value_next = w_hit_data;
          end else begin
            w_state_next     = ACCESS;
            w_mem_req_next   = 1'b1;
            w_mem_we_next    = MEM_W_en & ~MEM_R_en;
            w_mem_addr_next  = w_word_addr;
            w_mem_wdata_next = Val_Rm;
`ifdef MEM_LASTREAD_EN
            w_inval          = MEM_W_en & ~MEM_R_en;
`endif
          end
        end
      end
      ACCESS: begin
        w_freeze = 1'b1;
        if (mem_ack) begin
          w_state_next   = DONE;
          w_mem_req_next = 1'b0;
          w_mem_we_next  = 1'b0;
          if (!r_mem_we) begin
            w_read_value_next = mem_rdata;
`ifdef MEM_LASTREAD_EN
            w_fill            = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        // Pipeline advances this cycle; the next request is seen in IDLE.
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign freeze         = w_freeze;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign MEM_read_value = r_read_value;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
// Transaction-level model of the memory stage: each load/store is expanded
// into its expected per-cycle outputs (request cycle, ACCESS cycles, DONE),
// and a single negedge process compares the DUT against those expectations.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

  localparam int ADDR_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_en, MEM_W_en;
  logic [31:0] ALU_result, Val_Rm;
  logic [31:0] MEM_read_value;
  logic        freeze, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  mem_stage_sram_ctrl #(.DATA_BASE(1024), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_R_en      (MEM_R_en),
    .MEM_W_en      (MEM_W_en),
    .ALU_result    (ALU_result),
    .Val_Rm        (Val_Rm),
    .MEM_read_value(MEM_read_value),
    .freeze        (freeze),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        exp_freeze, exp_req, exp_we;
  logic [15:0] exp_addr;
  logic [31:0] exp_wdata, exp_rv;

  // Behavioural model state.
  logic [31:0] m_rv;
  logic        lr_valid;
  logic [15:0] lr_addr;
  logic [31:0] lr_data;

  // Monitor counters, written only by the compare process.
  int          frz_total = 0;
  int          req_total = 0;
  int          we_total  = 0;
  logic [15:0] seen_addr = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [31:0] alu);
    logic [31:0] off;
    off = alu - 32'd1024;
    return 16'((off / 32'd4) % 32'd65536);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check32("freeze", {31'b0, freeze}, {31'b0, exp_freeze});
      check32("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      check32("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      check32("MEM_read_value", MEM_read_value, exp_rv);
      if (exp_req) check32("mem_addr", {16'b0, mem_addr}, {16'b0, exp_addr});
      if (exp_req && exp_we) check32("mem_wdata", mem_wdata, exp_wdata);
    end
    if (freeze)  frz_total++;
    if (mem_we)  we_total++;
    if (mem_req) begin
      req_total++;
      seen_addr = mem_addr;
    end
  end

  task automatic set_idle_exp();
    exp_freeze = 1'b0;
    exp_req    = 1'b0;
    exp_we     = 1'b0;
    exp_rv     = m_rv;
  endtask

  // Idle cycles with spurious acks, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      MEM_R_en   = 1'b0;
      MEM_W_en   = 1'b0;
      mem_ack    = 1'($urandom);
      mem_rdata  = $urandom;
      ALU_result = $urandom;
      set_idle_exp();
    end
  endtask

  // One memory instruction; returns at #1 into its DONE cycle.
  task automatic do_txn(input bit r, input bit w, input logic [31:0] alu,
                        input logic [31:0] wdata, input int waits,
                        input logic [31:0] rdata);
    bit          is_wr;
    bit          hit;
    logic [15:0] wa;
    is_wr = w & ~r;
    wa    = word_of(alu);
    hit   = 1'b0;
`ifdef MEM_LASTREAD_EN
    hit = r && lr_valid && (lr_addr == wa);
`endif
    // Request cycle (IDLE with an enable): frozen, no request yet.
    @(posedge clk); #1;
    MEM_R_en   = r;
    MEM_W_en   = w;
    ALU_result = alu;
    Val_Rm     = wdata;
    mem_ack    = 1'($urandom);
    mem_rdata  = $urandom;
    exp_freeze = 1'b1;
    exp_req    = 1'b0;
    exp_we     = 1'b0;
    exp_rv     = m_rv;
    if (hit) begin
      @(posedge clk); #1;
      m_rv = lr_data;
    end else begin
      if (is_wr) lr_valid = 1'b0;
      for (int k = 0; k <= waits; k++) begin
        @(posedge clk); #1;
        mem_ack    = (k == waits);
        mem_rdata  = (k == waits) ? rdata : $urandom;
        exp_freeze = 1'b1;
        exp_req    = 1'b1;
        exp_we     = is_wr;
        exp_addr   = wa;
        exp_wdata  = wdata;
        exp_rv     = m_rv;
      end
      @(posedge clk); #1;
      if (r) begin
        m_rv     = rdata;
        lr_valid = 1'b1;
        lr_addr  = wa;
        lr_data  = rdata;
      end
    end
    // DONE: inputs here belong to nothing the controller should act on.
    MEM_R_en   = 1'($urandom);
    MEM_W_en   = 1'($urandom);
    mem_ack    = 1'($urandom);
    ALU_result = $urandom;
    set_idle_exp();
  endtask

  initial begin
    int f0, q0, w0;
    rst        = 1'b1;
    MEM_R_en   = 1'b0;
    MEM_W_en   = 1'b0;
    ALU_result = '0;
    Val_Rm     = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b0;
    m_rv       = '0;
    lr_valid   = 1'b0;
    lr_addr    = '0;
    lr_data    = '0;
    set_idle_exp();
    exp_addr   = '0;
    exp_wdata  = '0;

    repeat (3) @(posedge clk);
    #1;
    check32("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check32("reset_mem_we", {31'b0, mem_we}, 32'd0);
    check32("reset_mem_addr", {16'b0, mem_addr}, 32'd0);
    check32("reset_mem_wdata", mem_wdata, 32'd0);
    check32("reset_read_value", MEM_read_value, 32'd0);
    check32("reset_freeze", {31'b0, freeze}, 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Load with immediate ack.
    f0 = frz_total; q0 = req_total;
    do_txn(1'b1, 1'b0, 32'd1028, 32'd0, 0, 32'hDEADBEEF);
    check32("load_frozen_cycles", frz_total - f0, 32'd2);
    check32("load_req_cycles", req_total - q0, 32'd1);
    check32("load_addr", {16'b0, seen_addr}, 32'd1);
    check32("load_value", MEM_read_value, 32'hDEADBEEF);
    idle(2);

    // Store with 3 wait states.
    f0 = frz_total; q0 = req_total; w0 = we_total;
    do_txn(1'b0, 1'b1, 32'd1032, 32'h12345678, 3, 32'h0);
    check32("store_frozen_cycles", frz_total - f0, 32'd5);
    check32("store_req_cycles", req_total - q0, 32'd4);
    check32("store_we_cycles", we_total - w0, 32'd4);
    check32("store_addr", {16'b0, seen_addr}, 32'd2);
    check32("store_keeps_value", MEM_read_value, 32'hDEADBEEF);
    idle(1);

    // Address wrap below DATA_BASE.
    do_txn(1'b1, 1'b0, 32'd1020, 32'd0, 1, 32'h0BADCAFE);
    check32("wrap_addr", {16'b0, seen_addr}, 32'h0000FFFF);
    idle(1);

    // Both enables: treated as a read.
    w0 = we_total;
    do_txn(1'b1, 1'b1, 32'd1040, 32'hFFFF0000, 0, 32'hCAFEF00D);
    check32("both_en_we_cycles", we_total - w0, 32'd0);
    check32("both_en_value", MEM_read_value, 32'hCAFEF00D);
    idle(8);

    // Reset in the middle of an access.
    @(posedge clk); #1;
    MEM_R_en = 1'b1; ALU_result = 32'd1048; mem_ack = 1'b0;
    exp_freeze = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_rv = m_rv;
    @(posedge clk); #1;
    exp_freeze = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 16'd6;
    #2;
    rst = 1'b1; MEM_R_en = 1'b0;
    #1;
    check32("rst_mid_req", {31'b0, mem_req}, 32'd0);
    check32("rst_mid_freeze", {31'b0, freeze}, 32'd0);
    check32("rst_mid_value", MEM_read_value, 32'd0);
    m_rv = '0; lr_valid = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    check32("late_ack_value", MEM_read_value, 32'd0);
    check32("late_ack_req", {31'b0, mem_req}, 32'd0);
    idle(1);

`ifdef MEM_LASTREAD_EN
    // Repeated load served from the last-read buffer.
    do_txn(1'b1, 1'b0, 32'd1036, 32'd0, 2, 32'h55AA1234);
    idle(1);
    f0 = frz_total; q0 = req_total;
    do_txn(1'b1, 1'b0, 32'd1036, 32'd0, 2, 32'h0);
    check32("lr_hit_frozen", frz_total - f0, 32'd1);
    check32("lr_hit_req", req_total - q0, 32'd0);
    check32("lr_hit_value", MEM_read_value, 32'h55AA1234);
    // Store invalidates; the next load must go to the SRAM.
    do_txn(1'b0, 1'b1, 32'd1036, 32'h01020304, 0, 32'h0);
    q0 = req_total;
    do_txn(1'b1, 1'b0, 32'd1036, 32'd0, 0, 32'h01020304);
    check32("lr_inval_req", req_total - q0, 32'd1);
    idle(1);
`endif

    // Randomized instruction stream, back-to-back and with gaps.
    for (int t = 0; t < 250; t++) begin
      int          sel;
      logic [31:0] alu;
      sel = $urandom_range(0, 2);
      if ($urandom_range(0, 3) != 0) alu = 32'd1024 + 4 * $urandom_range(0, 3);
      else                           alu = $urandom;
      do_txn(sel != 1, sel != 0, alu, $urandom, $urandom_range(0, 3), $urandom);
      idle($urandom_range(0, 2));
    end
    idle(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
